// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - frame controller behind a UART byte receiver
//
// Hunts for the sync byte and collects length-prefixed payloads with an XOR checksum.
// Hands good frames to the host with a ready/ack handshake.
// Recovers the receiver from error by pulsing its reset.
//
// Ports:
//   CLK, reset                sys clock, synchronous active-high reset
//   rx_Do, rx_valid, rx_error receiver byte interface and error level
//   rx_reset                  reset pulse back to the receiver
//   pkt_ready, pkt_len        held-frame flag and its payload length
//   pkt_ack                   host release of the held frame
//   rd_addr, rd_data          registered payload read port
//   cnt_clr                   clear of all status counters
//   drop_cnt, rxerr_cnt,      saturating status counters
//   ovr_cnt
module uart_rx_frame_ctrl #(
    parameter int          P_MAX_LEN        = 16,
    parameter logic [7:0]  P_SYNC_BYTE      = 8'hA5,
    parameter int          P_TIMEOUT        = 4096,
    parameter int          P_RECOVER_CYCLES = 32
) (
    input  logic                               CLK,
    input  logic                               reset,
    input  logic [7:0]                         rx_Do,
    input  logic                               rx_valid,
    input  logic                               rx_error,
    output logic                               rx_reset,
    output logic                               pkt_ready,
    output logic [$clog2(P_MAX_LEN+1)-1:0]     pkt_len,
    input  logic                               pkt_ack,
    input  logic [$clog2(P_MAX_LEN)-1:0]       rd_addr,
    output logic [7:0]                         rd_data,
    input  logic                               cnt_clr,
    output logic [7:0]                         drop_cnt,
    output logic [7:0]                         rxerr_cnt,
    output logic [7:0]                         ovr_cnt
);
    localparam int LW = $clog2(P_MAX_LEN + 1);
    localparam int AW = $clog2(P_MAX_LEN);
    localparam int TW = $clog2(P_TIMEOUT + 1);
    localparam int RW = $clog2(P_RECOVER_CYCLES + 1);
    localparam logic [7:0] MAX_LEN_B = 8'(P_MAX_LEN);

    typedef enum logic [2:0] {F_IDLE, F_LEN, F_PAYLOAD, F_CHK, F_HOLD} frame_state_t;
    typedef enum logic {R_RUN, R_RECOVER} rec_state_t;

    frame_state_t state, state_nx;
    rec_state_t   rec_state, rec_nx;

    logic [RW-1:0] rec_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx_q;
    logic [7:0]    csum_q;
    logic [7:0]    mem [P_MAX_LEN];

    logic rec_start, byte_ok, tmo_hit, drop_inc, ovr_inc, chk_good;

    // A receiver error in RUN both starts recovery and swallows any byte in that cycle.
    assign rec_start = (rec_state == R_RUN) && rx_error;
    assign byte_ok   = rx_valid && (rec_state == R_RUN) && !rx_error;
    assign tmo_hit   = (tmo_cnt == '0);
    assign chk_good  = (rx_Do == csum_q);

    // ---------------- recovery sub-FSM ----------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            rec_state <= R_RUN;
            rec_cnt   <= '0;
        end else begin
            rec_state <= rec_nx;
            if (rec_start)
                rec_cnt <= RW'(P_RECOVER_CYCLES - 1);
            else if (rec_state == R_RECOVER && rec_cnt != '0)
                rec_cnt <= rec_cnt - RW'(1);
        end
    end

    always_comb begin
        rec_nx = rec_state;
        case (rec_state)
            R_RUN:     if (rx_error) rec_nx = R_RECOVER;
            R_RECOVER: if (rec_cnt == '0) rec_nx = R_RUN;
            default:   rec_nx = R_RUN;
        endcase
    end

    assign rx_reset = (rec_state == R_RECOVER);

    // ---------------- frame FSM ----------------
    always_ff @(posedge CLK) begin
        if (reset) state <= F_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        drop_inc = 1'b0;
        ovr_inc  = 1'b0;
        case (state)
            F_IDLE: begin
                if (byte_ok && rx_Do == P_SYNC_BYTE) state_nx = F_LEN;
            end
            F_LEN: begin
                if (byte_ok) begin
                    if (rx_Do != 8'd0 && rx_Do <= MAX_LEN_B) begin
                        state_nx = F_PAYLOAD;
                    end else begin
                        state_nx = F_IDLE;
                        drop_inc = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_nx = F_IDLE;
                    drop_inc = 1'b1;
                end
            end
            F_PAYLOAD: begin
                if (byte_ok) begin
                    if (idx_q + LW'(1) == len_q) state_nx = F_CHK;
                end else if (tmo_hit) begin
                    state_nx = F_IDLE;
                    drop_inc = 1'b1;
                end
            end
            F_CHK: begin
                if (byte_ok) begin
                    if (chk_good) begin
                        state_nx = F_HOLD;
                    end else begin
                        state_nx = F_IDLE;
                        drop_inc = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_nx = F_IDLE;
                    drop_inc = 1'b1;
                end
            end
            F_HOLD: begin
                ovr_inc = byte_ok;
                if (pkt_ack) state_nx = F_IDLE;
            end
            default: state_nx = F_IDLE;
        endcase
        // Recovery abort of an in-flight frame is silent, even if a timeout coincides.
        if (rec_start && (state == F_LEN || state == F_PAYLOAD || state == F_CHK)) begin
            state_nx = F_IDLE;
            drop_inc = 1'b0;
        end
    end

    assign pkt_ready = (state == F_HOLD);

    // ---------------- datapath ----------------
    always_ff @(posedge CLK) begin
        if (byte_ok)
            tmo_cnt <= TW'(P_TIMEOUT - 1);
        else if (!tmo_hit)
            tmo_cnt <= tmo_cnt - TW'(1);

        if (byte_ok && state == F_LEN) begin
            len_q  <= rx_Do[LW-1:0];
            csum_q <= rx_Do;
            idx_q  <= '0;
        end
        if (byte_ok && state == F_PAYLOAD) begin
            mem[idx_q[AW-1:0]] <= rx_Do;
            csum_q             <= csum_q ^ rx_Do;
            idx_q              <= idx_q + LW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            pkt_len <= '0;
            rd_data <= 8'h00;
        end else begin
            if (byte_ok && state == F_CHK && chk_good) pkt_len <= len_q;
            rd_data <= (LW'(rd_addr) < pkt_len) ? mem[rd_addr] : 8'h00;
        end
    end

    // ---------------- status counters ----------------
    function automatic logic [7:0] cnt_next(input logic [7:0] c, input logic inc);
        if (cnt_clr)                return 8'h00;
        if (inc && c != 8'hFF)      return c + 8'd1;
        return c;
    endfunction

    always_ff @(posedge CLK) begin
        if (reset) begin
            drop_cnt  <= 8'h00;
            rxerr_cnt <= 8'h00;
            ovr_cnt   <= 8'h00;
        end else begin
            drop_cnt  <= cnt_next(drop_cnt, drop_inc);
            rxerr_cnt <= cnt_next(rxerr_cnt, rec_start);
            ovr_cnt   <= cnt_next(ovr_cnt, ovr_inc);
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - scoreboard testbench for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;
    localparam int P_TIMEOUT = 4096;
    localparam int P_REC     = 32;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_Do = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_error = 1'b0;
    logic       rx_reset;
    logic       pkt_ready;
    logic [4:0] pkt_len;
    logic       pkt_ack = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic       cnt_clr = 1'b0;
    logic [7:0] drop_cnt, rxerr_cnt, ovr_cnt;

    int total = 0;
    int bad   = 0;

    int exp_len_q[$];
    int exp_rec_q[$];

    uart_rx_frame_ctrl dut (
        .CLK(CLK), .reset(reset), .rx_Do(rx_Do), .rx_valid(rx_valid), .rx_error(rx_error),
        .rx_reset(rx_reset), .pkt_ready(pkt_ready), .pkt_len(pkt_len), .pkt_ack(pkt_ack),
        .rd_addr(rd_addr), .rd_data(rd_data), .cnt_clr(cnt_clr), .drop_cnt(drop_cnt),
        .rxerr_cnt(rxerr_cnt), .ovr_cnt(ovr_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_Do    = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send(s[i]);
    endtask

    task automatic read_chk(input logic [3:0] a, input logic [7:0] exp);
        rd_addr = a;
        tick(1);
        check($sformatf("rd_data[%0d]", a), rd_data, exp);
    endtask

    task automatic ack();
        pkt_ack = 1'b1;
        tick(1);
        pkt_ack = 1'b0;
        check("pkt_ready_after_ack", pkt_ready, 0);
    endtask

    // Monitor: each new frame and each finished recovery pulse is checked against the scoreboard.
    logic prev_rdy = 1'b0;
    logic prev_rst = 1'b0;
    int   rst_width = 0;
    always @(negedge CLK) begin
        if (pkt_ready && !prev_rdy) begin
            if (exp_len_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_frame: got len=%0d expected none", pkt_len);
            end else begin
                check("frame_len", pkt_len, exp_len_q.pop_front());
            end
        end
        if (rx_reset) begin
            rst_width++;
        end else if (prev_rst) begin
            if (exp_rec_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_rx_reset: got width=%0d expected none", rst_width);
            end else begin
                check("rx_reset_width", rst_width, exp_rec_q.pop_front());
            end
            rst_width = 0;
        end
        prev_rdy = pkt_ready;
        prev_rst = rx_reset;
    end

    initial begin
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_pkt_ready", pkt_ready, 0);
        check("rst_pkt_len", pkt_len, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rx_reset", rx_reset, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_rxerr", rxerr_cnt, 0);
        check("rst_ovr", ovr_cnt, 0);

        // good frame
        exp_len_q.push_back(3);
        send_seq('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
        check("good_ready", pkt_ready, 1);
        check("good_len", pkt_len, 3);
        read_chk(0, 8'h11);
        read_chk(1, 8'h22);
        read_chk(2, 8'h33);
        read_chk(3, 8'h00);
        ack();

        // bad checksum, then bad lengths 00 and 11
        send_seq('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31});
        check("badchk_ready", pkt_ready, 0);
        check("badchk_drop", drop_cnt, 1);
        send_seq('{8'hA5, 8'h00});
        check("len0_drop", drop_cnt, 2);
        send_seq('{8'hA5, 8'h11});
        check("len17_drop", drop_cnt, 3);
        exp_len_q.push_back(1);
        send_seq('{8'hA5, 8'h01, 8'h5A, 8'h5B});
        check("len1_ready", pkt_ready, 1);
        read_chk(0, 8'h5A);
        ack();

        // timeout boundary
        send_seq('{8'hA5, 8'h02, 8'h10});
        tick(P_TIMEOUT - 1);
        check("tmo_not_yet", drop_cnt, 3);
        tick(1);
        check("tmo_drop", drop_cnt, 4);
        exp_len_q.push_back(2);
        send_seq('{8'hA5, 8'h02, 8'h0A, 8'h0B, 8'h03});
        check("after_tmo_ready", pkt_ready, 1);
        read_chk(1, 8'h0B);
        ack();

        // receiver error mid-payload
        send_seq('{8'hA5, 8'h03, 8'h44});
        exp_rec_q.push_back(P_REC);
        rx_error = 1'b1;
        tick(1);
        rx_error = 1'b0;
        check("rec_rx_reset", rx_reset, 1);
        check("rec_rxerr", rxerr_cnt, 1);
        tick(P_REC + 4);
        check("rec_done", rx_reset, 0);
        send_seq('{8'h55, 8'h66});
        check("rec_drop_unchanged", drop_cnt, 4);
        check("rec_no_frame", pkt_ready, 0);

        // overrun while holding
        exp_len_q.push_back(2);
        send_seq('{8'hA5, 8'h02, 8'hC1, 8'hC2, 8'h01});
        check("ovr_ready", pkt_ready, 1);
        send_seq('{8'hFF, 8'hEE, 8'hDD});
        check("ovr_3", ovr_cnt, 3);
        read_chk(0, 8'hC1);
        read_chk(1, 8'hC2);
        rx_Do = 8'hA5; rx_valid = 1'b1; pkt_ack = 1'b1;
        tick(1);
        rx_valid = 1'b0; pkt_ack = 1'b0;
        check("ovr_4", ovr_cnt, 4);
        check("ovr_ack_ready", pkt_ready, 0);
        send(8'h00);
        check("ovr_sync_discarded", drop_cnt, 4);

        // saturation and clear
        for (int i = 0; i < 300; i++) send_seq('{8'hA5, 8'h00});
        check("drop_sat", drop_cnt, 8'hFF);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        check("clr_drop", drop_cnt, 0);
        check("clr_rxerr", rxerr_cnt, 0);
        check("clr_ovr", ovr_cnt, 0);

        // reset during hold
        exp_len_q.push_back(1);
        send_seq('{8'hA5, 8'h01, 8'h12, 8'h13});
        check("hold_ready", pkt_ready, 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("rst_hold_ready", pkt_ready, 0);
        check("rst_hold_len", pkt_len, 0);
        rd_addr = 4'd0;
        tick(1);
        check("rst_hold_rd", rd_data, 0);

        tick(2);
        check("frames_left", exp_len_q.size(), 0);
        check("recovers_left", exp_rec_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
